// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pkg
// Purpose  : Shared definitions for the control-path pipeline: ARM condition
//            codes, NZCV flag bit positions and the per-stage control bits.
// Revision : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    // ARM condition field encodings (InstrD[31:28]); 4'b1111 behaves as AL.
    localparam logic [3:0] c_condEQ = 4'b0000;
    localparam logic [3:0] c_condNE = 4'b0001;
    localparam logic [3:0] c_condCS = 4'b0010;
    localparam logic [3:0] c_condCC = 4'b0011;
    localparam logic [3:0] c_condMI = 4'b0100;
    localparam logic [3:0] c_condPL = 4'b0101;
    localparam logic [3:0] c_condVS = 4'b0110;
    localparam logic [3:0] c_condVC = 4'b0111;
    localparam logic [3:0] c_condHI = 4'b1000;
    localparam logic [3:0] c_condLS = 4'b1001;
    localparam logic [3:0] c_condGE = 4'b1010;
    localparam logic [3:0] c_condLT = 4'b1011;
    localparam logic [3:0] c_condGT = 4'b1100;
    localparam logic [3:0] c_condLE = 4'b1101;
    localparam logic [3:0] c_condAL = 4'b1110;

    // Bit positions inside the {N,Z,C,V} flag vector.
    localparam int c_flagN = 3;
    localparam int c_flagZ = 2;
    localparam int c_flagC = 1;
    localparam int c_flagV = 0;

    // Control bits carried by every stage register. The opaque payload is
    // width-parameterised, so the owning module wraps this struct together
    // with a payload field of its own CTRL_W.
    typedef struct packed {
        logic regWrite;
        logic memWrite;
        logic memtoReg;
        logic pcSrc;
    } ctrlBits_t;

endpackage : ctrl_pkg
`default_nettype wire

// File: rtl/cond_eval.sv
`default_nettype none
// ============================================================================
// Module   : cond_eval
// Purpose  : Combinational ARM condition-code check against an NZCV vector.
// Ports    : Cond   in  4  condition field
//            Flags  in  4  {N,Z,C,V}
//            CondEx out 1  1 when the condition passes
// Revision : 1.0 - initial release
// ============================================================================
module cond_eval
    import ctrl_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;
    logic w_ge;

    assign w_n  = Flags[c_flagN];
    assign w_z  = Flags[c_flagZ];
    assign w_c  = Flags[c_flagC];
    assign w_v  = Flags[c_flagV];
    assign w_ge = (w_n == w_v);

    always_comb begin
        CondEx = 1'b1;
        case (Cond)
            c_condEQ: CondEx = w_z;
            c_condNE: CondEx = ~w_z;
            c_condCS: CondEx = w_c;
            c_condCC: CondEx = ~w_c;
            c_condMI: CondEx = w_n;
            c_condPL: CondEx = ~w_n;
            c_condVS: CondEx = w_v;
            c_condVC: CondEx = ~w_v;
            c_condHI: CondEx = w_c & ~w_z;
            c_condLS: CondEx = ~w_c | w_z;
            c_condGE: CondEx = w_ge;
            c_condLT: CondEx = ~w_ge;
            c_condGT: CondEx = ~w_z & w_ge;
            c_condLE: CondEx = w_z | ~w_ge;
            default:  CondEx = 1'b1;    // AL and the unused 4'b1111
        endcase
    end

endmodule : cond_eval
`default_nettype wire

// File: rtl/ctrl_pipe_param.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipe_param
// Purpose  : Control-path pipeline from Execute to Writeback. Applies ARM
//            condition gating, keeps the NZCV register, resolves branches
//            early in Decode, reports PC-write hazards and holds Execute for
//            iterative multi-cycle operations.
// Ports    : clk, reset (async, active-high)
//            FlushE                        bubble into E (ignored while busy)
//            CondD, FlagWriteD, *D         decoded controls / payload CtrlD
//            ALUFlagsE                     {N,Z,C,V} from the ALU
//            BranchTakenD, CondExE, BusyE  combinational status
//            FlagsQ                        architectural flags
//            MemWriteM, RegWriteM          stage-2 gated controls
//            RegWriteW, MemtoRegW, PCSrcW, CtrlW   final-stage controls
//            PCWrPendingF                  PC write in flight
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_pipe_param
    import ctrl_pkg::*;
#(
    parameter int NSTAGES    = 3,
    parameter int CTRL_W     = 8,
    parameter int MUL_CYCLES = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              FlushE,
    input  logic [3:0]        CondD,
    input  logic [1:0]        FlagWriteD,
    input  logic              RegWriteD,
    input  logic              MemWriteD,
    input  logic              MemtoRegD,
    input  logic              PCSrcD,
    input  logic              BranchD,
    input  logic              NoWriteD,
    input  logic              MultiCycleD,
    input  logic [CTRL_W-1:0] CtrlD,
    input  logic [3:0]        ALUFlagsE,
    output logic              BranchTakenD,
    output logic              CondExE,
    output logic              BusyE,
    output logic [3:0]        FlagsQ,
    output logic              MemWriteM,
    output logic              RegWriteM,
    output logic              RegWriteW,
    output logic              MemtoRegW,
    output logic              PCSrcW,
    output logic [CTRL_W-1:0] CtrlW,
    output logic              PCWrPendingF
);

    typedef struct packed {
        ctrlBits_t         ctl;
        logic [CTRL_W-1:0] payload;
    } stage_t;

    localparam int                c_cntW    = $clog2(MUL_CYCLES) + 1;
    localparam logic [c_cntW-1:0] c_cntLast = c_cntW'(MUL_CYCLES - 1);

    // ---------------- Stage-1 (E) register ----------------
    stage_t            w_bundleD;
    stage_t            r_bundleE;
    logic              r_noWriteE;
    logic [1:0]        r_flagWriteE;
    logic [3:0]        r_condE;
    logic              r_multiCycleE;
    logic [c_cntW-1:0] r_cnt;
    logic [3:0]        r_flagsQ;
    logic [3:0]        w_flagsNext;
    logic              w_condExE;
    logic              w_condExD;
    logic              w_busyE;
    stage_t            w_gatedE;

    always_comb begin
        w_bundleD.ctl.regWrite = RegWriteD;
        w_bundleD.ctl.memWrite = MemWriteD;
        w_bundleD.ctl.memtoReg = MemtoRegD;
        w_bundleD.ctl.pcSrc    = PCSrcD;
        w_bundleD.payload      = CtrlD;
    end

    // Busy outranks flush: a held multi-cycle op must not be discarded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bundleE     <= '0;
            r_noWriteE    <= 1'b0;
            r_flagWriteE  <= 2'b00;
            r_condE       <= 4'b0000;
            r_multiCycleE <= 1'b0;
        end else if (!w_busyE) begin
            if (FlushE) begin
                r_bundleE     <= '0;
                r_noWriteE    <= 1'b0;
                r_flagWriteE  <= 2'b00;
                r_condE       <= 4'b0000;
                r_multiCycleE <= 1'b0;
            end else begin
                r_bundleE     <= w_bundleD;
                r_noWriteE    <= NoWriteD;
                r_flagWriteE  <= FlagWriteD;
                r_condE       <= CondD;
                r_multiCycleE <= MultiCycleD;
            end
        end
    end

    cond_eval u_condE (
        .Cond   (r_condE),
        .Flags  (r_flagsQ),
        .CondEx (w_condExE)
    );

    // Early branch resolution sees the flags the E instruction is writing now.
    cond_eval u_condD (
        .Cond   (CondD),
        .Flags  (w_flagsNext),
        .CondEx (w_condExD)
    );

    // ---------------- Multi-cycle occupancy ----------------
    // cnt counts busy cycles; the final E cycle has cnt == MUL_CYCLES-1 and
    // is not busy, so the op spends MUL_CYCLES cycles in E in total.
    assign w_busyE = r_multiCycleE & w_condExE & (r_cnt < c_cntLast);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        r_cnt <= '0;
        else if (w_busyE) r_cnt <= r_cnt + c_cntW'(1);
        else              r_cnt <= '0;
    end

    // ---------------- Flags ----------------
    always_comb begin
        w_flagsNext = r_flagsQ;
        if (w_condExE && !w_busyE) begin
            if (r_flagWriteE[1]) begin
                w_flagsNext[c_flagN] = ALUFlagsE[c_flagN];
                w_flagsNext[c_flagZ] = ALUFlagsE[c_flagZ];
            end
            if (r_flagWriteE[0]) begin
                w_flagsNext[c_flagC] = ALUFlagsE[c_flagC];
                w_flagsNext[c_flagV] = ALUFlagsE[c_flagV];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_flagsQ <= 4'b0000;
        else       r_flagsQ <= w_flagsNext;
    end

    // ---------------- Condition gating at E ----------------
    always_comb begin
        w_gatedE              = r_bundleE;
        w_gatedE.ctl.regWrite = r_bundleE.ctl.regWrite & w_condExE & ~r_noWriteE;
        w_gatedE.ctl.memWrite = r_bundleE.ctl.memWrite & w_condExE;
        w_gatedE.ctl.pcSrc    = r_bundleE.ctl.pcSrc & w_condExE;
    end

    // ---------------- Stages 2..NSTAGES ----------------
    stage_t [NSTAGES:2] w_stageQ;

    for (genvar i = 2; i <= NSTAGES; i++) begin : g_stage
        stage_t r_q;
        if (i == 2) begin : g_head
            // Bubbles enter behind a held op until it completes.
            always_ff @(posedge clk or posedge reset) begin
                if (reset)        r_q <= '0;
                else if (w_busyE) r_q <= '0;
                else              r_q <= w_gatedE;
            end
        end else begin : g_tail
            always_ff @(posedge clk or posedge reset) begin
                if (reset) r_q <= '0;
                else       r_q <= w_stageQ[i-1];
            end
        end
        assign w_stageQ[i] = r_q;
    end

    // ---------------- PC-write hazard ----------------
    logic w_pipePend;

    always_comb begin
        w_pipePend = 1'b0;
        for (int k = 2; k < NSTAGES; k++) begin
            w_pipePend = w_pipePend | w_stageQ[k].ctl.pcSrc;
        end
    end

    // E contributes its raw PCSrc: its condition may still change the flags.
    assign PCWrPendingF = PCSrcD | r_bundleE.ctl.pcSrc | w_pipePend;

    // ---------------- Outputs ----------------
    assign BranchTakenD = BranchD & w_condExD;
    assign CondExE      = w_condExE;
    assign BusyE        = w_busyE;
    assign FlagsQ       = r_flagsQ;
    assign MemWriteM    = w_stageQ[2].ctl.memWrite;
    assign RegWriteM    = w_stageQ[2].ctl.regWrite;
    assign RegWriteW    = w_stageQ[NSTAGES].ctl.regWrite;
    assign MemtoRegW    = w_stageQ[NSTAGES].ctl.memtoReg;
    assign PCSrcW       = w_stageQ[NSTAGES].ctl.pcSrc;
    assign CtrlW        = w_stageQ[NSTAGES].payload;

    // Store intent has already been consumed by the memory stage.
    logic w_unused;
    assign w_unused = &{1'b0, w_stageQ[NSTAGES].ctl.memWrite};

endmodule : ctrl_pipe_param
`default_nettype wire

// File: tb/tb_ctrl_pipe_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_pipe_param
// Purpose  : Directed self-checking bench for ctrl_pipe_param configured with
//            NSTAGES=5, CTRL_W=8, MUL_CYCLES=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_pipe_param;

    localparam int NSTAGES    = 5;
    localparam int CTRL_W     = 8;
    localparam int MUL_CYCLES = 4;

    logic              clk;
    logic              reset;
    logic              FlushE;
    logic [3:0]        CondD;
    logic [1:0]        FlagWriteD;
    logic              RegWriteD, MemWriteD, MemtoRegD, PCSrcD;
    logic              BranchD, NoWriteD, MultiCycleD;
    logic [CTRL_W-1:0] CtrlD;
    logic [3:0]        ALUFlagsE;
    logic              BranchTakenD, CondExE, BusyE;
    logic [3:0]        FlagsQ;
    logic              MemWriteM, RegWriteM;
    logic              RegWriteW, MemtoRegW, PCSrcW;
    logic [CTRL_W-1:0] CtrlW;
    logic              PCWrPendingF;

    int checks   = 0;
    int failures = 0;

    ctrl_pipe_param #(
        .NSTAGES    (NSTAGES),
        .CTRL_W     (CTRL_W),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .FlushE       (FlushE),
        .CondD        (CondD),
        .FlagWriteD   (FlagWriteD),
        .RegWriteD    (RegWriteD),
        .MemWriteD    (MemWriteD),
        .MemtoRegD    (MemtoRegD),
        .PCSrcD       (PCSrcD),
        .BranchD      (BranchD),
        .NoWriteD     (NoWriteD),
        .MultiCycleD  (MultiCycleD),
        .CtrlD        (CtrlD),
        .ALUFlagsE    (ALUFlagsE),
        .BranchTakenD (BranchTakenD),
        .CondExE      (CondExE),
        .BusyE        (BusyE),
        .FlagsQ       (FlagsQ),
        .MemWriteM    (MemWriteM),
        .RegWriteM    (RegWriteM),
        .RegWriteW    (RegWriteW),
        .MemtoRegW    (MemtoRegW),
        .PCSrcW       (PCSrcW),
        .CtrlW        (CtrlW),
        .PCWrPendingF (PCWrPendingF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setIdle();
        FlushE      = 1'b0;
        CondD       = 4'b1110;
        FlagWriteD  = 2'b00;
        RegWriteD   = 1'b0;
        MemWriteD   = 1'b0;
        MemtoRegD   = 1'b0;
        PCSrcD      = 1'b0;
        BranchD     = 1'b0;
        NoWriteD    = 1'b0;
        MultiCycleD = 1'b0;
        CtrlD       = '0;
    endtask

    task automatic chkZeroOutputs(input string tag);
        chk({tag, ".FlagsQ"},    32'(FlagsQ),    32'h0);
        chk({tag, ".RegWriteM"}, 32'(RegWriteM), 32'h0);
        chk({tag, ".MemWriteM"}, 32'(MemWriteM), 32'h0);
        chk({tag, ".RegWriteW"}, 32'(RegWriteW), 32'h0);
        chk({tag, ".MemtoRegW"}, 32'(MemtoRegW), 32'h0);
        chk({tag, ".PCSrcW"},    32'(PCSrcW),    32'h0);
        chk({tag, ".CtrlW"},     32'(CtrlW),     32'h0);
        chk({tag, ".BusyE"},     32'(BusyE),     32'h0);
        chk({tag, ".PCWrPend"},  32'(PCWrPendingF), 32'h0);
    endtask

    initial begin
        logic [15:0] condTbl;

        setIdle();
        ALUFlagsE = 4'b0000;
        reset     = 1'b1;
        tick();
        tick();
        chkZeroOutputs("reset");
        reset = 1'b0;
        tick();

        // ---- ADDS sets Z, BEQ in D resolves against the new flags ----
        FlagWriteD = 2'b11;
        tick();
        ALUFlagsE = 4'b0100;
        setIdle();
        BranchD = 1'b1;
        CondD   = 4'b0000;      // EQ
        #1;
        chk("beq_early.BranchTakenD", 32'(BranchTakenD), 32'h1);
        chk("beq_early.FlagsQ_before", 32'(FlagsQ), 32'h0);
        tick();
        chk("adds.FlagsQ", 32'(FlagsQ), 32'h4);
        CondD = 4'b0001;        // NE with Z=1
        #1;
        chk("bne.BranchTakenD", 32'(BranchTakenD), 32'h0);
        ALUFlagsE = 4'b0000;

        // ---- NE fails with Z=1: writes suppressed, payload still flows ----
        setIdle();
        CondD     = 4'b0001;
        RegWriteD = 1'b1;
        MemWriteD = 1'b1;
        PCSrcD    = 1'b1;
        CtrlD     = 8'h3C;
        #1;
        chk("ne.PCWrPend_D", 32'(PCWrPendingF), 32'h1);
        tick();
        setIdle();
        #1;
        chk("ne.PCWrPend_E", 32'(PCWrPendingF), 32'h1);
        chk("ne.CondExE", 32'(CondExE), 32'h0);
        tick();
        chk("ne.RegWriteM", 32'(RegWriteM), 32'h0);
        chk("ne.MemWriteM", 32'(MemWriteM), 32'h0);
        chk("ne.PCWrPend_M", 32'(PCWrPendingF), 32'h0);
        tick();
        tick();
        tick();
        chk("ne.PCSrcW", 32'(PCSrcW), 32'h0);
        chk("ne.RegWriteW", 32'(RegWriteW), 32'h0);
        chk("ne.CtrlW", 32'(CtrlW), 32'h3C);

        // ---- NoWrite suppresses RegWrite even when the condition passes ----
        RegWriteD = 1'b1;
        NoWriteD  = 1'b1;
        tick();
        setIdle();
        #1;
        chk("nowrite.CondExE", 32'(CondExE), 32'h1);
        tick();
        chk("nowrite.RegWriteM", 32'(RegWriteM), 32'h0);

        // ---- Passing instruction: latency to M and W, hazard coverage ----
        setIdle();
        RegWriteD = 1'b1;
        MemWriteD = 1'b1;
        MemtoRegD = 1'b1;
        PCSrcD    = 1'b1;
        CtrlD     = 8'hA5;
        tick();
        setIdle();
        #1;
        chk("pass.PCWrPend_s1", 32'(PCWrPendingF), 32'h1);
        tick();
        chk("pass.RegWriteM", 32'(RegWriteM), 32'h1);
        chk("pass.MemWriteM", 32'(MemWriteM), 32'h1);
        chk("pass.PCWrPend_s2", 32'(PCWrPendingF), 32'h1);
        tick();
        chk("pass.PCWrPend_s3", 32'(PCWrPendingF), 32'h1);
        tick();
        chk("pass.PCWrPend_s4", 32'(PCWrPendingF), 32'h1);
        chk("pass.CtrlW_early", 32'(CtrlW), 32'h0);
        tick();
        chk("pass.CtrlW", 32'(CtrlW), 32'hA5);
        chk("pass.RegWriteW", 32'(RegWriteW), 32'h1);
        chk("pass.MemtoRegW", 32'(MemtoRegW), 32'h1);
        chk("pass.PCSrcW", 32'(PCSrcW), 32'h1);
        chk("pass.PCWrPend_W", 32'(PCWrPendingF), 32'h0);

        // ---- Multi-cycle op, 4 cycles in E, flags updated on completion ----
        MultiCycleD = 1'b1;
        RegWriteD   = 1'b1;
        FlagWriteD  = 2'b11;
        CtrlD       = 8'h77;
        ALUFlagsE   = 4'b1010;
        tick();
        setIdle();
        #1;
        chk("mul.Busy1", 32'(BusyE), 32'h1);
        chk("mul.Flags1", 32'(FlagsQ), 32'h4);
        tick();
        chk("mul.Busy2", 32'(BusyE), 32'h1);
        chk("mul.RegWriteM2", 32'(RegWriteM), 32'h0);
        chk("mul.Flags2", 32'(FlagsQ), 32'h4);
        tick();
        chk("mul.Busy3", 32'(BusyE), 32'h1);
        chk("mul.RegWriteM3", 32'(RegWriteM), 32'h0);
        tick();
        chk("mul.Busy4", 32'(BusyE), 32'h0);
        chk("mul.RegWriteM4", 32'(RegWriteM), 32'h0);
        chk("mul.Flags4", 32'(FlagsQ), 32'h4);
        tick();
        chk("mul.RegWriteM5", 32'(RegWriteM), 32'h1);
        chk("mul.FlagsDone", 32'(FlagsQ), 32'hA);
        ALUFlagsE = 4'b0000;
        tick();
        chk("mul.RegWriteM6", 32'(RegWriteM), 32'h0);

        // ---- All condition codes with N=1,C=1 (E idle, no flag writes) ----
        condTbl = 16'hE996;
        BranchD = 1'b1;
        for (int k = 0; k < 16; k++) begin
            CondD = 4'(k);
            #1;
            chk($sformatf("condNC.%0d", k), 32'(BranchTakenD), 32'(condTbl[k]));
        end
        setIdle();
        tick();

        // ---- FlushE while busy is ignored ----
        MultiCycleD = 1'b1;
        RegWriteD   = 1'b1;
        CtrlD       = 8'h11;
        tick();
        setIdle();
        FlushE = 1'b1;
        #1;
        chk("flushBusy.Busy1", 32'(BusyE), 32'h1);
        tick();
        chk("flushBusy.Busy2", 32'(BusyE), 32'h1);
        chk("flushBusy.RegWriteM2", 32'(RegWriteM), 32'h0);
        tick();
        chk("flushBusy.Busy3", 32'(BusyE), 32'h1);
        FlushE = 1'b0;
        tick();
        chk("flushBusy.Busy4", 32'(BusyE), 32'h0);
        tick();
        chk("flushBusy.RegWriteM", 32'(RegWriteM), 32'h1);
        tick();
        tick();
        tick();
        chk("flushBusy.CtrlW", 32'(CtrlW), 32'h11);
        chk("flushBusy.RegWriteW", 32'(RegWriteW), 32'h1);

        // ---- FlushE without busy loads a bubble ----
        RegWriteD = 1'b1;
        MemWriteD = 1'b1;
        PCSrcD    = 1'b1;
        CtrlD     = 8'hFF;
        FlushE    = 1'b1;
        tick();
        setIdle();
        #1;
        chk("flush.PCWrPend_E", 32'(PCWrPendingF), 32'h0);
        tick();
        chk("flush.RegWriteM", 32'(RegWriteM), 32'h0);
        chk("flush.MemWriteM", 32'(MemWriteM), 32'h0);
        tick();
        tick();
        tick();
        chk("flush.CtrlW", 32'(CtrlW), 32'h0);

        // ---- Reset in the second busy cycle ----
        MultiCycleD = 1'b1;
        RegWriteD   = 1'b1;
        CtrlD       = 8'h5A;
        tick();
        setIdle();
        tick();
        chk("rstBusy.BusyBefore", 32'(BusyE), 32'h1);
        chk("rstBusy.FlagsBefore", 32'(FlagsQ), 32'hA);
        reset = 1'b1;
        #1;
        chkZeroOutputs("rstBusy");
        tick();
        reset = 1'b0;
        tick();
        chk("rstBusy.BusyAfter", 32'(BusyE), 32'h0);
        chk("rstBusy.RegWriteM", 32'(RegWriteM), 32'h0);
        tick();
        chk("rstBusy.RegWriteM2", 32'(RegWriteM), 32'h0);

        // ---- All condition codes with flags clear ----
        condTbl = 16'hD6AA;
        BranchD = 1'b1;
        for (int k = 0; k < 16; k++) begin
            CondD = 4'(k);
            #1;
            chk($sformatf("condZero.%0d", k), 32'(BranchTakenD), 32'(condTbl[k]));
        end
        setIdle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ctrl_pipe_param
`default_nettype wire

// File: doc/ctrl_pipe_param.md
# ctrl_pipe_param

Parametrised control-path pipeline for the pipelined core. It takes decoded control bits from the Decode stage and carries them through a configurable number of stages, from Execute to Writeback. Along the way it applies ARM condition gating, updates the NZCV flags register, and computes early branch resolution and PC-write-pending hazard information. It also adds multi-cycle Execute occupancy (iterative multiply) with a busy/stall indication.

## Interface
- NSTAGES, 3: stages after Decode (1 = E, 2 = M, NSTAGES = W); legal ≥ 3
- CTRL_W, 8: width of opaque payload carried unmodified to W
- MUL_CYCLES, 3: E occupancy of a condition-passing multi-cycle op; legal ≥ 1
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-high
- FlushE  in  1  load a bubble into E instead of D contents
- CondD  in  4  InstrD[31:28]
- FlagWriteD  in  2  [1] update N,Z; [0] update C,V
- RegWriteD, MemWriteD, MemtoRegD, PCSrcD, BranchD, NoWriteD, MultiCycleD  in  1 each  decoded controls
- CtrlD  in  CTRL_W  payload
- ALUFlagsE  in  4  {N,Z,C,V} from the ALU
- BranchTakenD  out  1  BranchD & condition(CondD, FlagsNext)
- CondExE  out  1  condition of the E instruction against FlagsQ
- BusyE  out  1  E held; the hazard unit must stall F/D
- FlagsQ  out  4  architectural {N,Z,C,V}; CarryE = FlagsQ[1]
- MemWriteM, RegWriteM  out  1 each  stage-2 gated controls
- RegWriteW, MemtoRegW, PCSrcW  out  1 each  stage-NSTAGES controls
- CtrlW  out  CTRL_W  payload at W
- PCWrPendingF  out  1  PCSrcD | PCSrc of stages 1..NSTAGES-1

## Operation
- Stage-1 (E) register:
  - loads the D bundle each cycle unless BusyE=1, in which case it holds.
  - FlushE=1 with BusyE=0 loads all-zero control (payload zero).
  - FlushE=1 with BusyE=1 is ignored; busy has priority.
- Gating at E:
  - RegWriteG = RegWriteE & CondExE & ~NoWriteE
  - MemWriteG = MemWriteE & CondExE
  - PCSrcG = PCSrcE & CondExE
  - MemtoReg and payload pass ungated.
- Stage 2 register:
  - loads the gated bundle when E completes.
  - loads all-zero when BusyE=1 (bubble).
- Stages 3..NSTAGES shift unconditionally.
- Condition evaluation covers all 16 ARM codes (EQ..AL; code 1111 is treated as AL).
- Flags:
  - FlagsNext = FlagsQ, with N,Z replaced by ALUFlagsE if FlagWriteE[1], and C,V replaced if FlagWriteE[0].
  - Replacement happens only when CondExE=1 and BusyE=0.
  - FlagsQ <= FlagsNext every cycle.
- BranchTakenD uses FlagsNext, so flags set by the completing E instruction reach the D branch in the same cycle.
- Multi-cycle:
  - cnt is a $clog2(MUL_CYCLES)+1-bit register.
  - BusyE = MultiCycleE & CondExE & (cnt < MUL_CYCLES-1).
  - cnt increments while BusyE; it clears to 0 otherwise.
  - The op therefore occupies E for MUL_CYCLES cycles. A condition-failed op, or MUL_CYCLES=1, is never busy.
- PCWrPendingF ORs PCSrcD, raw PCSrcE, and gated PCSrc of stages 2..NSTAGES-1.

## Timing
- Reset: every output, all stage registers, FlagsQ and cnt are 0 asynchronously.
- BusyE and BranchTakenD are combinational. Outputs are registered except BusyE, CondExE, BranchTakenD and PCWrPendingF.
- Latency with no busy: D → W output in NSTAGES cycles; D → M outputs in 2 cycles.
- A multi-cycle op adds MUL_CYCLES-1 cycles. Exactly MUL_CYCLES-1 bubbles enter stage 2 behind nothing, ahead of the op.
- Back-to-back multi-cycle ops: cnt returns to 0 on the completing cycle, so the second op starts counting on entry.
- Reset mid-busy: cnt and the E register are cleared; no residual bubble.

## Structure
- Package ctrl_pkg holds:
  - condition-code localparams (EQ=0000 … AL=1110)
  - flag index constants (N=3, Z=2, C=1, V=0)
  - the stage-bundle packed struct (RegWrite, MemWrite, MemtoReg, PCSrc, payload)
- Sub-module cond_eval: combinational (Cond[3:0], Flags[3:0]) → CondEx. It is instantiated twice, once for E and once for early D.
- Stages 3..NSTAGES are a generate-loop register array.

## Test plan
- Flags Z=1: ADDS (FlagWriteD=11, ALUFlagsE=0100) then BEQ in D in the same cycle → BranchTakenD=1 and FlagsQ=0100 next cycle.
- CondD=NE with Z=1, RegWriteD=1, PCSrcD=1 → RegWriteM=0, PCSrcW=0; PCWrPendingF=1 while in D and E (raw), 0 once in M.
- MUL_CYCLES=4, MultiCycleD=1 with AL → BusyE=1 for 3 cycles; RegWriteM pulses once, 4 cycles after entry to E; FlagsQ unchanged while busy.
- FlushE asserted during BusyE → ignored, the op completes. FlushE with BusyE=0 → stage-2 bundle all zero next cycle.
- NSTAGES=5, CTRL_W=8: CtrlD=0xA5 → CtrlW=0xA5 exactly 5 cycles later; PCWrPendingF covers stages 1–4.
- reset pulsed in the 2nd busy cycle → all outputs 0 immediately; BusyE=0 after release.
